// File: rtl/scan_pkg.sv
// Shared types and width helpers for the scan chain controller.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2
    } scan_state_e;

    // Counter width for a counter spanning 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scan_clk_div.sv
// Scan clock generator: CLK_DIV system clocks per half period, held low while disabled.
module scan_clk_div
    import scan_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic scan_clk,
    output logic rise_strobe,
    output logic fall_strobe
);
    localparam int HW = cnt_w(CLK_DIV);
    localparam logic [HW-1:0] HALF_TC = HW'(CLK_DIV - 1);

    logic [HW-1:0] half_cnt;
    logic          half_tc;

    // Strobes mark the system clock edge at which scan_clk flips.
    assign half_tc     = en && (half_cnt == HALF_TC);
    assign rise_strobe = half_tc && !scan_clk;
    assign fall_strobe = half_tc && scan_clk;

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            half_cnt <= '0;
            scan_clk <= 1'b0;
        end else if (half_tc) begin
            half_cnt <= '0;
            scan_clk <= !scan_clk;
        end else begin
            half_cnt <= half_cnt + HW'(1);
        end
    end

endmodule

// File: rtl/scan_controller.sv
// Chain-end driver: shifts a host word into the scan chain, pulses a capture
// period, and collects the bits returning from the last slot.
//
//   state   | meaning
//   IDLE    | scan clock parked low, waiting for start
//   SHIFT   | CHAIN_LEN scan periods, tx out / rx in
//   CAPTURE | one scan period with scan_select high
module scan_controller
    import scan_pkg::*;
#(
    parameter int  NUM_BLOCKS  = 4,
    parameter int  SCAN_LENGTH = 2,
    parameter int  CLK_DIV     = 2,
    localparam int CHAIN_LEN   = NUM_BLOCKS * SCAN_LENGTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] wdata,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] rdata,
    output logic                 scan_clk_out,
    output logic                 scan_data_out,
    output logic                 scan_select_out,
    input  logic                 scan_data_in
);
    localparam int BW = cnt_w(CHAIN_LEN);
    localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN - 1);

    scan_state_e          state, state_next;
    logic [BW-1:0]        bit_cnt;
    logic [CHAIN_LEN-1:0] tx_sr, rx_sr;
    logic                 rise, fall, div_en, last_bit;

    assign div_en   = (state != IDLE);
    assign busy     = div_en;
    assign last_bit = (bit_cnt == '0);
    // tx_sr shifts in zeros, so it is already clear by the time CAPTURE starts.
    assign scan_data_out = tx_sr[CHAIN_LEN-1];

    scan_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk        (clk),
        .reset      (reset),
        .en         (div_en),
        .scan_clk   (scan_clk_out),
        .rise_strobe(rise),
        .fall_strobe(fall)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)           state_next = SHIFT;
            SHIFT:   if (fall && last_bit) state_next = CAPTURE;
            CAPTURE: if (fall)            state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_sr           <= '0;
            rx_sr           <= '0;
            rdata           <= '0;
            bit_cnt         <= '0;
            done            <= 1'b0;
            scan_select_out <= 1'b0;
        end else begin
            done            <= 1'b0;
            scan_select_out <= (state_next == CAPTURE);
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_sr   <= wdata;
                        bit_cnt <= LAST_BIT;
                    end
                end
                SHIFT: begin
                    if (rise) rx_sr <= {rx_sr[CHAIN_LEN-2:0], scan_data_in};
                    if (fall) begin
                        tx_sr <= tx_sr << 1;
                        if (!last_bit) bit_cnt <= bit_cnt - BW'(1);
                    end
                end
                CAPTURE: begin
                    if (fall) begin
                        done  <= 1'b1;
                        rdata <= rx_sr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_controller.sv
// Runs three controller configurations against a behavioural scan chain and a
// frame-level timing model.
module tb_scan_controller;
    localparam int NCFG = 3;

    logic clk = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_fin   = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int NB = (g == 1) ? 2 : 4;
        localparam int SL = 2;
        localparam int CD = (g == 0) ? 2 : (g == 1) ? 1 : 3;
        localparam int CL = NB * SL;
        localparam int N  = 2 * CD * (CL + 1);
        localparam logic [CL-1:0] DIR = (g == 1) ? CL'(4'b1011) : CL'(8'hA5);

        logic          reset, start, busy, done, sclk, sdo, ssel, sdi;
        logic [CL-1:0] wdata, rdata;

        scan_controller #(
            .NUM_BLOCKS (NB),
            .SCAN_LENGTH(SL),
            .CLK_DIV    (CD)
        ) dut (
            .clk            (clk),
            .reset          (reset),
            .start          (start),
            .wdata          (wdata),
            .busy           (busy),
            .done           (done),
            .rdata          (rdata),
            .scan_clk_out   (sclk),
            .scan_data_out  (sdo),
            .scan_select_out(ssel),
            .scan_data_in   (sdi)
        );

        // Behavioural chain: posedge flops with capture mux (module_data_out =
        // ~module_data_in), plus a negedge end flop per slot.
        logic [CL-1:0] chain;
        logic [CL-1:0] chain_prev;
        logic [NB-1:0] tail;
        logic [NB:0]   link;

        assign link       = {tail, sdo};
        assign chain_prev = {chain[CL-2:0], 1'b0};
        assign sdi        = tail[NB-1];

        always @(posedge sclk)
            for (int i = 0; i < CL; i++)
                chain[i] <= ssel ? ~chain[i] : ((i % SL == 0) ? link[i / SL] : chain_prev[i]);

        always @(negedge sclk)
            for (int b = 0; b < NB; b++)
                tail[b] <= chain[b * SL + SL - 1];

        // Frame model: m_age 0 = idle, 1..N = cycle within the frame.
        int            m_age = 0;
        bit            m_live = 0, m_done = 0, m_known = 0, m_prev_ok = 0;
        logic [CL-1:0] m_word = '0, m_prev = '0, m_rdata = '0;

        always @(negedge clk) begin
            int         x, p;
            logic [4:0] exp_o;
            if (m_live) begin
                exp_o    = '0;
                exp_o[3] = m_done;
                if (m_age > 0) begin
                    x        = m_age - 1;
                    p        = x / (2 * CD);
                    exp_o[4] = 1'b1;
                    exp_o[2] = ((x % (2 * CD)) >= CD);
                    exp_o[1] = (p == CL);
                    if (p < CL) exp_o[0] = m_word[CL-1-p];
                end
                check($sformatf("c%0d_outs", g), 64'({busy, done, sclk, ssel, sdo}), 64'(exp_o));
                if (m_known) check($sformatf("c%0d_rdata", g), 64'(rdata), 64'(m_rdata));
                if (m_age == 2 * CD * CL + 1)
                    check($sformatf("c%0d_chain", g), 64'(chain), 64'(m_word));
            end
            if (reset) begin
                m_live    = 1;
                m_age     = 0;
                m_done    = 0;
                m_known   = 1;
                m_rdata   = '0;
                m_prev_ok = 0;
            end else begin
                m_done = (m_age == N);
                if (m_age == 0) begin
                    if (start) begin
                        m_word = wdata;
                        m_age  = 1;
                    end
                end else if (m_age == N) begin
                    m_rdata   = ~m_prev;
                    m_known   = m_prev_ok;
                    m_prev    = m_word;
                    m_prev_ok = 1;
                    m_age     = 0;
                end else begin
                    m_age++;
                end
            end
        end

        task automatic cyc(input int n);
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        endtask

        task automatic frame(input logic [CL-1:0] w, input int gap);
            start = 1'b1;
            wdata = w;
            cyc(1);
            start = 1'b0;
            wdata = CL'($urandom);
            cyc(N + gap);
        endtask

        initial begin
            reset = 1'b1;
            start = 1'b0;
            wdata = '0;
            cyc(3);
            reset = 1'b0;
            cyc(6);
            reset = 1'b1;
            cyc(1);
            reset = 1'b0;
            cyc(4);
            // directed word, then back-to-back zero frame and a readback frame
            frame(DIR, 0);
            frame('0, 0);
            frame(CL'($urandom), 2);
            // start held high with changing wdata
            repeat (2 * N + 3) begin
                start = 1'b1;
                wdata = CL'($urandom);
                cyc(1);
            end
            start = 1'b0;
            cyc(N + 2);
            // reset in the middle of shift bit 3
            start = 1'b1;
            wdata = CL'($urandom);
            cyc(1);
            start = 1'b0;
            cyc(6 * CD + 1);
            reset = 1'b1;
            cyc(1);
            reset = 1'b0;
            cyc(2);
            frame(CL'(8'h3C), 1);
            frame(CL'($urandom), 0);
            repeat (8) frame(CL'($urandom), $urandom_range(0, 3));
            cyc(N + 4);
            n_fin++;
        end
    end

    initial begin
        int k = 0;
        while (n_fin < NCFG && k < 50000) begin
            @(posedge clk);
            k++;
        end
        if (n_fin < NCFG) check("timeout", 64'(n_fin), 64'(NCFG));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
